// File: rtl/control_unit.sv
// Main decoder for the single-cycle MIPS-style datapath.
// Maps the instruction opcode to a control word and registers it once per
// clock, so the datapath sees a glitch-free control word.
module control_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    output logic       memToReg,
    output logic       memWrite,
    output logic       memRead,
    output logic       branch,
    output logic [3:0] ALUOp,
    output logic       ALUSrcBControl,
    output logic       regDst,
    output logic       regWrite,
    output logic       jmp,
    output logic       illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BGT   = 6'b001110;
    localparam logic [5:0] OP_BGE   = 6'b010001;
    localparam logic [5:0] OP_BLT   = 6'b010010;
    localparam logic [5:0] OP_BLE   = 6'b010011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_RTYPE = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_EQ    = 4'b0100;
    localparam logic [3:0] ALU_NE    = 4'b0101;
    localparam logic [3:0] ALU_GT    = 4'b0110;
    localparam logic [3:0] ALU_GE    = 4'b0111;
    localparam logic [3:0] ALU_LT    = 4'b1000;
    localparam logic [3:0] ALU_LE    = 4'b1001;
    localparam logic [3:0] ALU_ILL   = 4'b1111;

    logic       mem_to_reg_d, mem_to_reg_q;
    logic       mem_write_d,  mem_write_q;
    logic       mem_read_d,   mem_read_q;
    logic       branch_d,     branch_q;
    logic [3:0] alu_op_d,     alu_op_q;
    logic       alu_src_b_d,  alu_src_b_q;
    logic       reg_dst_d,    reg_dst_q;
    logic       reg_write_d,  reg_write_q;
    logic       jmp_d,        jmp_q;
    logic       illegal_d,    illegal_q;

    // Combinational opcode decode; everything defaults to a NOP word.
    always_comb begin
        mem_to_reg_d = 1'b0;
        mem_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        branch_d     = 1'b0;
        alu_op_d     = ALU_ADD;
        alu_src_b_d  = 1'b0;
        reg_dst_d    = 1'b0;
        reg_write_d  = 1'b0;
        jmp_d        = 1'b0;
        illegal_d    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                reg_dst_d   = 1'b1;
                reg_write_d = 1'b1;
                alu_op_d    = ALU_RTYPE;
            end
            OP_ADDI: begin
                reg_write_d = 1'b1;
                alu_src_b_d = 1'b1;
            end
            OP_ANDI: begin
                reg_write_d = 1'b1;
                alu_src_b_d = 1'b1;
                alu_op_d    = ALU_AND;
            end
            OP_ORI: begin
                reg_write_d = 1'b1;
                alu_src_b_d = 1'b1;
                alu_op_d    = ALU_OR;
            end
            OP_LW: begin
                mem_read_d   = 1'b1;
                mem_to_reg_d = 1'b1;
                reg_write_d  = 1'b1;
                alu_src_b_d  = 1'b1;
            end
            OP_SW: begin
                mem_write_d = 1'b1;
                alu_src_b_d = 1'b1;
            end
            OP_BEQ: begin branch_d = 1'b1; alu_op_d = ALU_EQ; end
            OP_BNE: begin branch_d = 1'b1; alu_op_d = ALU_NE; end
            OP_BGT: begin branch_d = 1'b1; alu_op_d = ALU_GT; end
            OP_BGE: begin branch_d = 1'b1; alu_op_d = ALU_GE; end
            OP_BLT: begin branch_d = 1'b1; alu_op_d = ALU_LT; end
            OP_BLE: begin branch_d = 1'b1; alu_op_d = ALU_LE; end
            OP_J: begin
                jmp_d = 1'b1;
            end
            // Link value and $31 destination are chosen in the datapath
            // from jmp & regWrite, so regDst stays 0 here.
            OP_JAL: begin
                jmp_d       = 1'b1;
                reg_write_d = 1'b1;
            end
            default: begin
                alu_op_d  = ALU_ILL;
                illegal_d = 1'b1;
            end
        endcase
    end

    // Single output register bank; async reset yields an all-zero NOP word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_to_reg_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            branch_q     <= 1'b0;
            alu_op_q     <= 4'b0000;
            alu_src_b_q  <= 1'b0;
            reg_dst_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            jmp_q        <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            mem_to_reg_q <= mem_to_reg_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
            branch_q     <= branch_d;
            alu_op_q     <= alu_op_d;
            alu_src_b_q  <= alu_src_b_d;
            reg_dst_q    <= reg_dst_d;
            reg_write_q  <= reg_write_d;
            jmp_q        <= jmp_d;
            illegal_q    <= illegal_d;
        end
    end

    assign memToReg       = mem_to_reg_q;
    assign memWrite       = mem_write_q;
    assign memRead        = mem_read_q;
    assign branch         = branch_q;
    assign ALUOp          = alu_op_q;
    assign ALUSrcBControl = alu_src_b_q;
    assign regDst         = reg_dst_q;
    assign regWrite       = reg_write_q;
    assign jmp            = jmp_q;
    assign illegal        = illegal_q;

    // Control-word invariants on the registered outputs.
    a_no_rd_wr: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_read_q && mem_write_q));
    a_no_br_jmp: assert property (@(posedge clk) disable iff (!rst_n)
        !(branch_q && jmp_q));
    a_no_wb_on_st_br: assert property (@(posedge clk) disable iff (!rst_n)
        (mem_write_q || branch_q) |-> !reg_write_q);

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed steps plus random opcodes,
// compared against a table-driven reference of the decode.
module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       memToReg, memWrite, memRead, branch;
    logic [3:0] ALUOp;
    logic       ALUSrcBControl, regDst, regWrite, jmp, illegal;

    int errors = 0;
    int checks = 0;

    control_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .opcode         (opcode),
        .memToReg       (memToReg),
        .memWrite       (memWrite),
        .memRead        (memRead),
        .branch         (branch),
        .ALUOp          (ALUOp),
        .ALUSrcBControl (ALUSrcBControl),
        .regDst         (regDst),
        .regWrite       (regWrite),
        .jmp            (jmp),
        .illegal        (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word layout: {memToReg, memWrite, memRead, branch, ALUOp[3:0],
    //               ALUSrcB, regDst, regWrite, jmp, illegal}
    function automatic logic [12:0] pack(input logic m2r, input logic mw,
                                         input logic mr, input logic br,
                                         input logic [3:0] op, input logic srcb,
                                         input logic rd, input logic rw,
                                         input logic j, input logic ill);
        return {m2r, mw, mr, br, op, srcb, rd, rw, j, ill};
    endfunction

    // Reference decode written straight from the instruction table.
    function automatic logic [12:0] model(input logic [5:0] op);
        case (op)
            6'b000000: return pack(0,0,0,0,4'd1,0,1,1,0,0); // R-type
            6'b001000: return pack(0,0,0,0,4'd0,1,0,1,0,0); // ADDI
            6'b001100: return pack(0,0,0,0,4'd2,1,0,1,0,0); // ANDI
            6'b001101: return pack(0,0,0,0,4'd3,1,0,1,0,0); // ORI
            6'b100011: return pack(1,0,1,0,4'd0,1,0,1,0,0); // LW
            6'b101011: return pack(0,1,0,0,4'd0,1,0,0,0,0); // SW
            6'b000100: return pack(0,0,0,1,4'd4,0,0,0,0,0); // BEQ
            6'b000101: return pack(0,0,0,1,4'd5,0,0,0,0,0); // BNE
            6'b001110: return pack(0,0,0,1,4'd6,0,0,0,0,0); // BGT
            6'b010001: return pack(0,0,0,1,4'd7,0,0,0,0,0); // BGE
            6'b010010: return pack(0,0,0,1,4'd8,0,0,0,0,0); // BLT
            6'b010011: return pack(0,0,0,1,4'd9,0,0,0,0,0); // BLE
            6'b000010: return pack(0,0,0,0,4'd0,0,0,0,1,0); // J
            6'b000011: return pack(0,0,0,0,4'd0,0,0,1,1,0); // JAL
            default:   return pack(0,0,0,0,4'd15,0,0,0,0,1);
        endcase
    endfunction

    function automatic logic [12:0] observed();
        return {memToReg, memWrite, memRead, branch, ALUOp,
                ALUSrcBControl, regDst, regWrite, jmp, illegal};
    endfunction

    task automatic check(input string tag, input logic [12:0] exp);
        logic [12:0] obs;
        obs = observed();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Present an opcode between edges, clock it in, then check after the edge.
    task automatic step(input logic [5:0] op, input string tag);
        @(negedge clk);
        opcode = op;
        @(posedge clk);
        #1;
        check(tag, model(op));
    endtask

    logic [5:0] rop;
    logic [5:0] branches [6];

    initial begin
        branches[0] = 6'b000100; branches[1] = 6'b000101;
        branches[2] = 6'b001110; branches[3] = 6'b010001;
        branches[4] = 6'b010010; branches[5] = 6'b010011;

        // Load a non-NOP word, then hit async reset with LW still on the bus.
        rst_n  = 1'b1;
        opcode = 6'b100011;
        @(posedge clk);
        #1;
        check("pre_reset_lw", model(6'b100011));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 13'd0);
        repeat (2) @(posedge clk);
        #1;
        check("held_in_reset", 13'd0);

        @(negedge clk);
        rst_n  = 1'b1;
        opcode = 6'b000000;
        @(posedge clk);
        #1;
        check("rtype_first_edge", model(6'b000000));
        step(6'b100011, "lw_back_to_back");

        // Opcode changes between edges must not reach the outputs.
        #2;
        opcode = 6'b101011;
        #1;
        check("hold_between_edges", model(6'b100011));

        step(6'b101011, "sw");
        step(6'b001000, "addi");
        step(6'b001100, "andi");
        step(6'b001101, "ori");
        for (int i = 0; i < 6; i++)
            step(branches[i], $sformatf("branch_%0d", i));
        step(6'b000010, "j");
        step(6'b000011, "jal");
        step(6'b111111, "illegal_3f");

        // Reset mid-run, then recover on the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_reset", 13'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        opcode = 6'b001101;
        @(posedge clk);
        #1;
        check("recover_after_reset", model(6'b001101));

        // Random opcodes, every edge, no bubbles.
        for (int i = 0; i < 200; i++) begin
            rop = 6'($urandom_range(0, 63));
            step(rop, $sformatf("rand_%0d_op%b", i, rop));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
